// File: rtl/team_04_wb_gpio_resp.sv
// team_04_wb_gpio_resp: Wishbone classic responder for breakout GPIOs
// (output/OEB registers, synchronized inputs, W1C rising-edge status, level irq).
module team_04_wb_gpio_resp #(
    parameter int          NUM_GPIO  = 34,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [31:0]         ADR_I,
    input  logic [31:0]         DAT_I,
    input  logic [3:0]          SEL_I,
    input  logic                WE_I,
    input  logic                STB_I,
    input  logic                CYC_I,
    output logic [31:0]         DAT_O,
    output logic                ACK_O,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);
    logic [NUM_GPIO-1:0] out_r, oeb_r, edge_r, s1, s2, s3;
    logic [63:0] out_w, oeb_w, edge_w, in_w, wmask, wdat, rd64, out_n, oeb_n, edge_n;
    logic [31:0] bmask, rdata;
    logic sel, go, wr, unused_ok;

    assign unused_ok = ^ADR_I[1:0];
    assign gpio_out = en ? out_r : '0;
    assign gpio_oeb = en ? oeb_r : '1;

    // Registers are viewed as 64-bit words so LO/HI share one lane mask; bits
    // above NUM_GPIO fall away on truncation and read back as zero.
    always_comb begin
        sel    = CYC_I & STB_I & (ADR_I[31:5] == BASE_ADDR[31:5]);
        go     = sel & ~ACK_O;
        wr     = go & WE_I;
        bmask  = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
        wmask  = ADR_I[2] ? {bmask, 32'h0} : {32'h0, bmask};
        wdat   = {DAT_I, DAT_I};
        out_w  = 64'(out_r);
        oeb_w  = 64'(oeb_r);
        edge_w = 64'(edge_r);
        in_w   = 64'(s2);
        out_n  = (wr && ADR_I[4:3] == 2'd0) ? (out_w & ~wmask) | (wdat & wmask) : out_w;
        oeb_n  = (wr && ADR_I[4:3] == 2'd1) ? (oeb_w & ~wmask) | (wdat & wmask) : oeb_w;
        edge_n = (edge_w & ~((wr && ADR_I[4:3] == 2'd3) ? wdat & wmask : 64'h0)) | 64'(s2 & ~s3);
        rd64   = ADR_I[4] ? (ADR_I[3] ? edge_w : in_w) : (ADR_I[3] ? oeb_w : out_w);
        rdata  = ADR_I[2] ? rd64[63:32] : rd64[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r  <= '0;
            oeb_r  <= '1;
            edge_r <= '0;
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            irq    <= 1'b0;
            ACK_O  <= 1'b0;
            DAT_O  <= 32'h0;
        end else begin
            s1     <= gpio_in;
            s2     <= s1;
            s3     <= s2;
            out_r  <= out_n[NUM_GPIO-1:0];
            oeb_r  <= oeb_n[NUM_GPIO-1:0];
            edge_r <= edge_n[NUM_GPIO-1:0];
            irq    <= |edge_n[NUM_GPIO-1:0];
            ACK_O  <= go;
            if (go) DAT_O <= rdata;
        end
    end
endmodule

// File: tb/tb_team_04_wb_gpio_resp.sv
// tb_team_04_wb_gpio_resp: directed bench for the Wishbone GPIO responder.
module tb_team_04_wb_gpio_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [31:0] ADR_I = '0, DAT_I = '0, DAT_O;
    logic [3:0]  SEL_I = '0;
    logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0, ACK_O, irq;
    logic [33:0] gpio_in = '0, gpio_out, gpio_oeb;
    int          n_assert = 0, n_fail = 0;
    logic [31:0] rd;
    int          cyc;
    logic [5:0]  pat;

    team_04_wb_gpio_resp dut (
        .clk(clk), .rst(rst), .en(en), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
        .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One classic cycle; cyc = clocks until ACK (0 = none within 5 clocks).
    task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic we, output logic [31:0] r, output int c);
        @(negedge clk);
        ADR_I = a; DAT_I = d; SEL_I = s; WE_I = we; CYC_I = 1'b1; STB_I = 1'b1;
        c = 0;
        r = '0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (ACK_O) begin
                c = i;
                r = DAT_O;
                break;
            end
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_ack", 64'(ACK_O), 64'd0);
        check("rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        check("rst_out", 64'(gpio_out), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_dat", 64'(DAT_O), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wb(32'h3000_0000, 32'hA5A5_5A5A, 4'hF, 1'b1, rd, cyc);
        check("wr_lat", 64'(cyc), 64'd1);
        wb(32'h3000_0004, 32'h0000_0003, 4'hF, 1'b1, rd, cyc);
        check("wr_hi_lat", 64'(cyc), 64'd1);
        wb(32'h3000_0008, 32'h0, 4'hF, 1'b1, rd, cyc);
        wb(32'h3000_000C, 32'h0, 4'hF, 1'b1, rd, cyc);
        #1;
        check("pad_out", 64'(gpio_out), 64'h3_A5A5_5A5A);
        check("pad_oeb", 64'(gpio_oeb), 64'd0);
        wb(32'h3000_0000, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rd_out_lo", 64'(rd), 64'hA5A5_5A5A);
        wb(32'h3000_0004, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rd_out_hi", 64'(rd), 64'h3);
        wb(32'h3000_0010, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rd_in_lo", 64'(rd), 64'h0);

        wb(32'h3000_0000, 32'h0, 4'hF, 1'b1, rd, cyc);
        wb(32'h3000_0000, 32'hFFFF_FFFF, 4'b0010, 1'b1, rd, cyc);
        wb(32'h3000_0000, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rd_lane", 64'(rd), 64'h0000_FF00);
        wb(32'h3000_0004, 32'hFFFF_FFFC, 4'hF, 1'b1, rd, cyc);
        wb(32'h3000_0004, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rd_hi_unimpl", 64'(rd), 64'h0);
        #1;
        check("pad_lane", 64'(gpio_out), 64'h0_0000_FF00);
        en = 1'b0;
        #1;
        check("en0_out", 64'(gpio_out), 64'd0);
        check("en0_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        en = 1'b1;
        #1;
        check("en1_out", 64'(gpio_out), 64'h0_0000_FF00);
        check("en1_oeb", 64'(gpio_oeb), 64'd0);

        wb(32'h3000_0020, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, cyc);
        check("dec_hi_noack", 64'(cyc), 64'd0);
        wb(32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, cyc);
        check("dec_base_noack", 64'(cyc), 64'd0);
        wb(32'h3000_0000, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("dec_unchanged", 64'(rd), 64'h0000_FF00);

        @(negedge clk);
        gpio_in[33] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        check("edge_irq", 64'(irq), 64'd1);
        wb(32'h3000_001C, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("edge_hi", 64'(rd), 64'h2);
        wb(32'h3000_0014, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("in_hi", 64'(rd), 64'h2);
        wb(32'h3000_001C, 32'h2, 4'hF, 1'b1, rd, cyc);
        check("clr_irq", 64'(irq), 64'd0);
        wb(32'h3000_001C, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("clr_edge", 64'(rd), 64'h0);

        gpio_in[33] = 1'b0;
        repeat (4) @(negedge clk);
        gpio_in[33] = 1'b1;
        repeat (2) @(negedge clk);
        ADR_I = 32'h3000_001C; DAT_I = 32'h2; SEL_I = 4'hF; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
        @(negedge clk);
        check("coinc_ack", 64'(ACK_O), 64'd1);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        check("coinc_irq", 64'(irq), 64'd1);
        wb(32'h3000_001C, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("coinc_edge", 64'(rd), 64'h2);

        @(negedge clk);
        ADR_I = 32'h3000_0010; WE_I = 1'b0; SEL_I = 4'h0; CYC_I = 1'b1; STB_I = 1'b1;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            pat = {pat[4:0], ACK_O};
        end
        check("held_pattern", 64'(pat), 64'b010101);
        CYC_I = 1'b0; STB_I = 1'b0;
        repeat (2) @(negedge clk);

        ADR_I = 32'h3000_0000; DAT_I = 32'hDEAD_BEEF; SEL_I = 4'hF; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
        #2 CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(negedge clk);
        check("abort_noack", 64'(ACK_O), 64'd0);
        wb(32'h3000_0000, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("abort_unchanged", 64'(rd), 64'h0000_FF00);

        @(negedge clk);
        ADR_I = 32'h3000_0008; DAT_I = 32'h0000_1234; SEL_I = 4'hF; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
        #2 rst = 1'b1;
        #1 check("rst_mid_ack", 64'(ACK_O), 64'd0);
        @(negedge clk);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wb(32'h3000_0008, 32'h0, 4'h0, 1'b0, rd, cyc);
        check("rst_mid_oeb_lo", 64'(rd), 64'hFFFF_FFFF);
        check("rst_mid_pad_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
